// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard information in, pipeline stage control out
// master is the pipeline datapath side, slave is the hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_UsesRt;
  logic             ID_Halt;
  logic             EX_MemRead;
  logic [4:0]       EX_rt;
  logic             EX_BranchTaken;
  logic             MEM_Busy;
  logic             PCWre;
  logic             PCSrcBranch;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             ID_EX_Hold;
  logic             EX_MEM_Hold;
  logic             Halted;
  logic             Fault;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_rs, ID_rt, ID_UsesRt, ID_Halt, EX_MemRead, EX_rt, EX_BranchTaken, MEM_Busy,
    input  PCWre, PCSrcBranch, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold,
           EX_MEM_Hold, Halted, Fault, StallCount, FlushCount
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRt, ID_Halt, EX_MemRead, EX_rt, EX_BranchTaken, MEM_Busy,
    output PCWre, PCSrcBranch, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, ID_EX_Hold,
           EX_MEM_Hold, Halted, Fault, StallCount, FlushCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush/drain sequencer
// Priority in RUN: memory freeze, taken branch, load-use bubble, halt.
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int TIMEOUT      = 255,
  parameter int CNT_W        = 16
) (
  input logic                   Clk,
  input logic                   Reset,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int FW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [FW-1:0]    freeze_cnt_q, freeze_cnt_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic busy, load_use, ev_branch, ev_stall, ev_halt, timeout_hit;

  assign busy     = hz.MEM_Busy;
  assign load_use = hz.EX_MemRead && (hz.EX_rt != 5'd0) &&
                    ((hz.EX_rt == hz.ID_rs) || (hz.ID_UsesRt && (hz.EX_rt == hz.ID_rt)));

  assign ev_branch = (state_q == RUN) && !busy && hz.EX_BranchTaken;
  assign ev_stall  = (state_q == RUN) && !busy && !hz.EX_BranchTaken && load_use;
  assign ev_halt   = (state_q == RUN) && !busy && !hz.EX_BranchTaken && !load_use && hz.ID_Halt;

  // Fault fires on the edge where the busy run reaches TIMEOUT; HALTED follows one edge later.
  assign timeout_hit = (state_q != HALTED) && busy && (freeze_cnt_q == FW'(TIMEOUT - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (fault_q)      state_d = HALTED;
        else if (ev_halt) state_d = DRAIN;
      end
      DRAIN: begin
        if (fault_q || (!busy && drain_cnt_q == '0)) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end

  always_comb begin
    hz.PCWre       = 1'b1;
    hz.PCSrcBranch = 1'b0;
    hz.IF_ID_Write = 1'b1;
    hz.IF_ID_Flush = 1'b0;
    hz.ID_EX_Flush = 1'b0;
    hz.ID_EX_Hold  = 1'b0;
    hz.EX_MEM_Hold = 1'b0;
    case (state_q)
      RUN: begin
        if (busy) begin
          hz.PCWre       = 1'b0;
          hz.IF_ID_Write = 1'b0;
          hz.ID_EX_Hold  = 1'b1;
          hz.EX_MEM_Hold = 1'b1;
        end else if (hz.EX_BranchTaken) begin
          hz.PCSrcBranch = 1'b1;
          hz.IF_ID_Flush = 1'b1;
          hz.ID_EX_Flush = 1'b1;
        end else if (load_use || hz.ID_Halt) begin
          hz.PCWre       = 1'b0;
          hz.IF_ID_Write = 1'b0;
          hz.ID_EX_Flush = 1'b1;
        end
      end
      DRAIN: begin
        hz.PCWre       = 1'b0;
        hz.IF_ID_Write = 1'b0;
        hz.ID_EX_Flush = 1'b1;
        hz.ID_EX_Hold  = busy;
        hz.EX_MEM_Hold = busy;
      end
      default: begin
        hz.PCWre       = 1'b0;
        hz.IF_ID_Write = 1'b0;
        hz.ID_EX_Flush = 1'b1;
      end
    endcase
  end

  always_comb begin
    drain_cnt_d  = drain_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    fault_d      = fault_q | timeout_hit;
    stall_cnt_d  = stall_cnt_q + (ev_stall ? CNT_W'(1) : CNT_W'(0));
    flush_cnt_d  = flush_cnt_q + (ev_branch ? CNT_W'(1) : CNT_W'(0));
    if (ev_halt) begin
      drain_cnt_d = DW'(DRAIN_CYCLES - 1);
    end else if (state_q == DRAIN && !busy && drain_cnt_q != '0) begin
      drain_cnt_d = drain_cnt_q - DW'(1);
    end
    if (!busy) begin
      freeze_cnt_d = '0;
    end else if (state_q != HALTED && freeze_cnt_q != FW'(TIMEOUT)) begin
      freeze_cnt_d = freeze_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      drain_cnt_q  <= '0;
      freeze_cnt_q <= '0;
      fault_q      <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      drain_cnt_q  <= drain_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
      fault_q      <= fault_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign hz.Halted     = (state_q == HALTED);
  assign hz.Fault      = fault_q;
  assign hz.StallCount = stall_cnt_q;
  assign hz.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
// ctl packs {PCWre,PCSrcBranch,IF_ID_Write,IF_ID_Flush,ID_EX_Flush,ID_EX_Hold,EX_MEM_Hold,Halted,Fault}.
module tb_pipeline_hazard_ctrl;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .TIMEOUT(255), .CNT_W(16)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .hz   (bus)
  );

  always #5 Clk = ~Clk;

  logic [8:0] ctl;
  assign ctl = {bus.PCWre, bus.PCSrcBranch, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush,
                bus.ID_EX_Hold, bus.EX_MEM_Hold, bus.Halted, bus.Fault};

  localparam logic [8:0] CTL_RUN     = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] CTL_BR      = 9'b1_1_1_1_1_0_0_0_0;
  localparam logic [8:0] CTL_BUBBLE  = 9'b0_0_0_0_1_0_0_0_0;
  localparam logic [8:0] CTL_FRZ     = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] CTL_DRN_FRZ = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] CTL_HALTED  = 9'b0_0_0_0_1_0_0_1_0;
  localparam logic [8:0] CTL_FRZ_F   = 9'b0_0_0_0_0_1_1_0_1;
  localparam logic [8:0] CTL_HALT_F  = 9'b0_0_0_0_1_0_0_1_1;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ID_rs = 5'd0; bus.ID_rt = 5'd0; bus.ID_UsesRt = 1'b0; bus.ID_Halt = 1'b0;
    bus.EX_MemRead = 1'b0; bus.EX_rt = 5'd0; bus.EX_BranchTaken = 1'b0; bus.MEM_Busy = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    step(); step();
    Reset = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, CTL_RUN); end
    checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.StallCount); end
    checks++; if (bus.FlushCount !== 16'd0) begin errors++; $display("FAIL reset_flush got %0d exp 0", bus.FlushCount); end
    step();
  endtask

  task automatic test_load_use();
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd5; bus.ID_rs = 5'd5;
    #1;
    checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL lu_rs_stall got %b exp %b", ctl, CTL_BUBBLE); end
    step();
    idle_inputs();
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_one_bubble got %b exp %b", ctl, CTL_RUN); end
    checks++; if (bus.StallCount !== 16'd1) begin errors++; $display("FAIL lu_count1 got %0d exp 1", bus.StallCount); end
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd0; bus.ID_rs = 5'd0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_r0_nostall got %b exp %b", ctl, CTL_RUN); end
    step();
    bus.EX_rt = 5'd7; bus.ID_rs = 5'd3; bus.ID_rt = 5'd7; bus.ID_UsesRt = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL lu_rt_unused got %b exp %b", ctl, CTL_RUN); end
    bus.ID_UsesRt = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL lu_rt_stall got %b exp %b", ctl, CTL_BUBBLE); end
    step();
    idle_inputs();
    #1;
    checks++; if (bus.StallCount !== 16'd2) begin errors++; $display("FAIL lu_count2 got %0d exp 2", bus.StallCount); end
  endtask

  task automatic test_branch_vs_load();
    bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd9; bus.ID_rs = 5'd9; bus.EX_BranchTaken = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL br_wins got %b exp %b", ctl, CTL_BR); end
    step();
    idle_inputs();
    #1;
    checks++; if (bus.FlushCount !== 16'd1) begin errors++; $display("FAIL br_flush1 got %0d exp 1", bus.FlushCount); end
    checks++; if (bus.StallCount !== 16'd2) begin errors++; $display("FAIL br_stall_kept got %0d exp 2", bus.StallCount); end
  endtask

  task automatic test_freeze_branch();
    bus.MEM_Busy = 1'b1; bus.EX_BranchTaken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ctl !== CTL_FRZ) begin errors++; $display("FAIL frz_hold%0d got %b exp %b", i, ctl, CTL_FRZ); end
      step();
    end
    checks++; if (bus.FlushCount !== 16'd1) begin errors++; $display("FAIL frz_noflush got %0d exp 1", bus.FlushCount); end
    bus.MEM_Busy = 1'b0;
    #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL frz_release_br got %b exp %b", ctl, CTL_BR); end
    step();
    idle_inputs();
    #1;
    checks++; if (bus.FlushCount !== 16'd2) begin errors++; $display("FAIL frz_flush2 got %0d exp 2", bus.FlushCount); end
  endtask

  task automatic test_halt_branch();
    bus.ID_Halt = 1'b1; bus.EX_BranchTaken = 1'b1;
    #1;
    checks++; if (ctl !== CTL_BR) begin errors++; $display("FAIL hb_br_wins got %b exp %b", ctl, CTL_BR); end
    step();
    idle_inputs();
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL hb_still_run got %b exp %b", ctl, CTL_RUN); end
    checks++; if (bus.FlushCount !== 16'd3) begin errors++; $display("FAIL hb_flush3 got %0d exp 3", bus.FlushCount); end
  endtask

  task automatic test_halt_drain();
    logic [8:0] exp;
    bus.ID_Halt = 1'b1; bus.EX_MemRead = 1'b1; bus.EX_rt = 5'd4; bus.ID_rs = 5'd4;
    #1;
    checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL hs_stall got %b exp %b", ctl, CTL_BUBBLE); end
    step();
    bus.EX_MemRead = 1'b0;
    #1;
    checks++; if (bus.StallCount !== 16'd3) begin errors++; $display("FAIL hs_stall3 got %0d exp 3", bus.StallCount); end
    checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL hs_halt_retry got %b exp %b", ctl, CTL_BUBBLE); end
    step();
    idle_inputs();
    for (int i = 1; i <= 6; i++) begin
      bus.MEM_Busy = (i == 2 || i == 3);
      bus.EX_BranchTaken = (i == 4);
      exp = (i == 6) ? CTL_HALTED : ((i == 2 || i == 3) ? CTL_DRN_FRZ : CTL_BUBBLE);
      #1;
      checks++; if (ctl !== exp) begin errors++; $display("FAIL drain_c%0d got %b exp %b", i, ctl, exp); end
      step();
    end
    idle_inputs();
    #1;
    checks++; if (ctl !== CTL_HALTED) begin errors++; $display("FAIL halted_sticky got %b exp %b", ctl, CTL_HALTED); end
    checks++; if (bus.FlushCount !== 16'd3) begin errors++; $display("FAIL drain_br_ignored got %0d exp 3", bus.FlushCount); end
  endtask

  task automatic test_watchdog();
    Reset = 1'b1;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL wd_reset_ctl got %b exp %b", ctl, CTL_RUN); end
    checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL wd_reset_stall got %0d exp 0", bus.StallCount); end
    Reset = 1'b0;
    step();
    bus.MEM_Busy = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      #1;
      if (k == 255) begin
        checks++; if (ctl !== CTL_FRZ) begin errors++; $display("FAIL wd_c255 got %b exp %b", ctl, CTL_FRZ); end
      end
      if (k == 256) begin
        checks++; if (ctl !== CTL_FRZ_F) begin errors++; $display("FAIL wd_fault got %b exp %b", ctl, CTL_FRZ_F); end
      end
      step();
    end
    #1;
    checks++; if (ctl !== CTL_HALT_F) begin errors++; $display("FAIL wd_halted got %b exp %b", ctl, CTL_HALT_F); end
    bus.MEM_Busy = 1'b0;
    Reset = 1'b1;
    #1;
    checks++; if (ctl !== CTL_RUN) begin errors++; $display("FAIL wd_async_clear got %b exp %b", ctl, CTL_RUN); end
    Reset = 1'b0;
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_vs_load();
    test_freeze_branch();
    test_halt_branch();
    test_halt_drain();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It decides, every cycle, which stages advance, which hold, and which are flushed. It drives PC write-enable, IF/ID write and flush, ID/EX flush and hold, and EX/MEM hold. It resolves load-use, taken-branch and memory-wait hazards, runs a halt-drain sequence and a memory-wait watchdog, and keeps stall and flush statistics.

Parameters:
DRAIN_CYCLES, 3, bubbles issued after a halt before the pipeline counts as empty (EX, MEM, WB).
TIMEOUT, 255, consecutive MEM_Busy cycles tolerated before Fault.
CNT_W, 16, width of the statistics counters.

Ports:
Clk  in  1  clock; all state updates on posedge.
Reset  in  1  asynchronous, active-high.
ID_rs  in  5  source register of the instruction in ID.
ID_rt  in  5  second source register of the instruction in ID.
ID_UsesRt  in  1  ID instruction reads rt as a source.
ID_Halt  in  1  ID holds the halt instruction.
EX_MemRead  in  1  EX holds a load.
EX_rt  in  5  load destination register in EX.
EX_BranchTaken  in  1  branch or jump resolved taken in EX.
MEM_Busy  in  1  data memory not ready.
PCWre  out  1  PC register load enable.
PCSrcBranch  out  1  selects the EX branch target into PC.
IF_ID_Write  out  1  IF/ID register load enable.
IF_ID_Flush  out  1  IF/ID register loads a nop.
ID_EX_Flush  out  1  ID/EX register loads a nop.
ID_EX_Hold  out  1  ID/EX register keeps its contents.
EX_MEM_Hold  out  1  EX/MEM register keeps its contents.
Halted  out  1  pipeline drained or faulted.
Fault  out  1  watchdog expired (sticky).
StallCount  out  CNT_W  load-use bubbles inserted.
FlushCount  out  CNT_W  taken-branch flushes.

Behaviour:
- State machine: RUN, DRAIN, HALTED. State and all counters are registered.
- Control outputs are combinational from the current state and inputs, and are valid before the next sampling edge.
- Reset (asynchronous, any time, including mid-drain or mid-freeze):
  - state goes to RUN, DrainCnt=0, FreezeCnt=0.
  - Fault=0, StallCount=0, FlushCount=0.
  - Reset has priority over every other event.
- Default in RUN with no event: PCWre=1, IF_ID_Write=1, every other control output 0.
- Event priority within RUN (highest first):
  1. Freeze, when MEM_Busy=1: PCWre=0, IF_ID_Write=0, ID_EX_Hold=1, EX_MEM_Hold=1, no flushes. EX_BranchTaken and load-use are ignored this cycle; they are re-evaluated once MEM_Busy drops.
  2. Branch, when EX_BranchTaken=1: PCWre=1, PCSrcBranch=1, IF_ID_Flush=1, ID_EX_Flush=1. FlushCount increments.
  3. Load-use, when EX_MemRead=1, EX_rt≠0, and (EX_rt==ID_rs or (ID_UsesRt and EX_rt==ID_rt)): PCWre=0, IF_ID_Write=0, ID_EX_Flush=1. StallCount increments. The condition clears on the next cycle because EX then holds the nop. Exactly one bubble per hazard.
  4. Halt, when ID_Halt=1: PCWre=0, IF_ID_Write=0, ID_EX_Flush=1. DrainCnt loads DRAIN_CYCLES-1 and the state moves to DRAIN.
- Halt collisions:
  - Halt together with a taken branch: the branch wins and the halt is flushed.
  - Halt together with a load-use hazard: the stall wins and the halt is retried next cycle.
- DRAIN:
  - PCWre=0, IF_ID_Write=0, ID_EX_Flush=1 every cycle.
  - DrainCnt decrements each non-busy cycle.
  - When MEM_Busy=1, freeze outputs apply, ID_EX_Flush is still asserted, and DrainCnt holds.
  - EX_BranchTaken is ignored.
  - Move to HALTED on a non-busy cycle when DrainCnt==0.
- HALTED:
  - Halted=1, PCWre=0, IF_ID_Write=0, ID_EX_Flush=1.
  - No exit except Reset.
- Watchdog:
  - FreezeCnt increments on each MEM_Busy=1 cycle in any state other than HALTED, and clears when MEM_Busy=0.
  - When FreezeCnt reaches TIMEOUT with MEM_Busy still 1: Fault=1 and the state moves to HALTED on the next edge.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Reset mid-run → all control outputs at RUN defaults (PCWre=1, IF_ID_Write=1), counters 0, Halted=0, Fault=0.
- EX_MemRead=1, EX_rt=5, ID_rs=5 for one cycle → PCWre=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 1 cycle; StallCount=1. Repeat with EX_rt=0 → no stall.
- EX_BranchTaken=1 together with a load-use match → PCSrcBranch=1, IF_ID_Flush=1, ID_EX_Flush=1, PCWre=1; FlushCount=1, StallCount unchanged.
- ID_Halt=1, then MEM_Busy=1 for 2 cycles during DRAIN → Halted rises 5 cycles after the halt cycle (3 drain cycles + 2 frozen); no PC writes after the halt cycle.
- MEM_Busy=1 held for 256 cycles → Fault=1 once 255 cycles have been counted, Halted=1 on the next cycle; asynchronous Reset clears both.
- MEM_Busy=1 with EX_BranchTaken=1 → hold outputs only and no flush; after MEM_Busy drops, the flush occurs and FlushCount=1.
